// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus: start gate, instruction-memory port, redirect input and decode handshake.
interface inst_fetch_unit_if;
  logic        in_done_load_inst;
  logic [63:0] out_inst_addr;
  logic [31:0] in_inst;
  logic        in_redirect_valid;
  logic [63:0] in_redirect_pc;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_fetch_fault;
  logic        out_halted;

  modport master (
    input  in_done_load_inst,
    output out_inst_addr,
    input  in_inst,
    input  in_redirect_valid,
    input  in_redirect_pc,
    output out_valid,
    input  in_ready,
    output out_inst,
    output out_pc,
    output out_fetch_fault,
    output out_halted
  );

  modport slave (
    output in_done_load_inst,
    input  out_inst_addr,
    output in_inst,
    output in_redirect_valid,
    output in_redirect_pc,
    input  out_valid,
    output in_ready,
    input  out_inst,
    input  out_pc,
    input  out_fetch_fault,
    input  out_halted
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// PC/fetch stage with a circular {pc, inst} buffer towards decode.
// Optional macro IFU_HALT_ON_ZERO_EN: a zero instruction word halts fetch instead of being queued.
module inst_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_unit_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LastPtr  = PTR_W'(DEPTH - 1);

  localparam logic [1:0] StWaitLoad = 2'd0;
  localparam logic [1:0] StFetch    = 2'd1;
  localparam logic [1:0] StFault    = 2'd2;
`ifdef IFU_HALT_ON_ZERO_EN
  localparam logic [1:0] StHalt     = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [63:0]      fifo_pc_q   [DEPTH];
  logic [31:0]      fifo_inst_q [DEPTH];

  logic head_valid;
  logic fire;
  logic room;
  logic redirect;
  logic misaligned;
  logic zero_word;
  logic enq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count_q != '0);
  assign fire       = head_valid && bus.in_ready;
  // A full buffer still has room when the head leaves in the same cycle.
  assign room       = (count_q < DepthCnt) || fire;
  assign redirect   = bus.in_redirect_valid && (state_q != StWaitLoad);
  assign misaligned = (bus.in_redirect_pc[1:0] != 2'b00);

`ifdef IFU_HALT_ON_ZERO_EN
  assign zero_word = (bus.in_inst == 32'h0);
`else
  assign zero_word = 1'b0;
`endif

  assign enq = (state_q == StFetch) && !redirect && room && !zero_word;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (redirect) begin
      // Flush wins over enqueue; a same-cycle fire is already consumed by decode.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = bus.in_redirect_pc;
      state_d  = misaligned ? StFault : StFetch;
    end else begin
      case (state_q)
        StWaitLoad: if (bus.in_done_load_inst) state_d = StFetch;
`ifdef IFU_HALT_ON_ZERO_EN
        StFetch:    if (zero_word) state_d = StHalt;
`endif
        default:    ;
      endcase

      if (enq) begin
        pc_d     = pc_q + 64'd4;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (fire) rd_ptr_d = ptr_inc(rd_ptr_q);

      case ({enq, fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StWaitLoad;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      fifo_pc_q[wr_ptr_q]   <= pc_q;
      fifo_inst_q[wr_ptr_q] <= bus.in_inst;
    end
  end

  assign bus.out_inst_addr   = pc_q;
  assign bus.out_valid       = head_valid;
  assign bus.out_inst        = head_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
  assign bus.out_pc          = head_valid ? fifo_pc_q[rd_ptr_q] : 64'h0;
  assign bus.out_fetch_fault = (state_q == StFault);

`ifdef IFU_HALT_ON_ZERO_EN
  assign bus.out_halted = (state_q == StHalt);
`else
  assign bus.out_halted = 1'b0;
`endif

endmodule
